store_align_unit: RTL and testbench

Store-path counterpart to the load data extender, placed between the MEM-stage store request and the word-addressed Data Memory write port. It converts a byte-addressed SB/SH/SW request into word-aligned write beats, each with a shifted data word and a 4-bit byte-enable. A store that crosses a word boundary is split into two sequential beats, and the pipeline is stalled until every beat has been acknowledged.

---
 rtl/store_align_unit.sv | 135 +++++++++++++
 tb/tb_store_align_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_align_unit.sv
// Store alignment: turns a byte-addressed SB/SH/SW into one or two
// word-aligned write beats with byte enables, stalling until acked.
module store_align_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        store_valid,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  output logic        stall,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  k_q;
  logic [29:0] word_q;
  logic [31:0] data_q;
  logic [3:0]  base_q;
  logic        split_q;

  logic        req;
  logic        is_sh;
  logic        is_sw;
  logic [3:0]  base_in;
  logic        split_in;
  logic [31:0] b0_data;
  logic [3:0]  b0_we;
  logic [5:0]  b1_sh;
  logic [2:0]  b1_msh;
  logic [31:0] b1_data;
  logic [3:0]  b1_we;
  logic [31:0] b1_addr;

  assign req   = store_valid & (store_type != 2'b00);
  assign is_sh = (store_type == 2'b10);
  assign is_sw = (store_type == 2'b11);

  always_comb begin
    base_in = 4'b0000;
    unique case (1'b1)
      (store_type == 2'b01): base_in = 4'b0001;
      is_sh:                 base_in = 4'b0011;
      is_sw:                 base_in = 4'b1111;
      default:               base_in = 4'b0000;
    endcase
  end

  assign split_in = (is_sh & (addr[1:0] == 2'd3))
                  | (is_sw & (addr[1:0] != 2'd0));

  assign b0_data = wdata << {addr[1:0], 3'b000};
  assign b0_we   = base_in << addr[1:0];

  // second beat only exists for k!=0, so both shift amounts stay in range
  assign b1_sh   = 6'd32 - {1'b0, k_q, 3'b000};
  assign b1_msh  = 3'd4 - {1'b0, k_q};
  assign b1_data = data_q >> b1_sh;
  assign b1_we   = base_q >> b1_msh;
  assign b1_addr = {word_q + 30'd1, 2'b00};

  assign done = mem_ack & (((state == BEAT0) & ~split_q)
                           | (state == BEAT1));
  assign stall = ((state == IDLE) & req)
               | ((state != IDLE) & ~done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k_q       <= 2'd0;
      word_q    <= 30'd0;
      data_q    <= 32'd0;
      base_q    <= 4'd0;
      split_q   <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_we    <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            k_q       <= addr[1:0];
            word_q    <= addr[31:2];
            data_q    <= wdata;
            base_q    <= base_in;
            split_q   <= split_in;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= b0_data;
            mem_we    <= b0_we;
            state     <= BEAT0;
          end
        end
        BEAT0: begin
          if (mem_ack) begin
            if (split_q) begin
              mem_addr  <= b1_addr;
              mem_wdata <= b1_data;
              mem_we    <= b1_we;
              state     <= BEAT1;
            end else begin
              mem_addr  <= 32'd0;
              mem_wdata <= 32'd0;
              mem_we    <= 4'd0;
              state     <= IDLE;
            end
          end
        end
        BEAT1: begin
          if (mem_ack) begin
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_we    <= 4'd0;
            state     <= IDLE;
          end
        end
        default: begin
          mem_addr  <= 32'd0;
          mem_wdata <= 32'd0;
          mem_we    <= 4'd0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// Bench for store_align_unit: vector table, byte-lane model for random
// stores, and hand sequences for reset, ignored requests and drops.
module tb_store_align_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        store_valid;
  logic [1:0]  store_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic        stall;
  logic        done;

  store_align_unit dut (
    .clk(clk), .rst(rst), .store_valid(store_valid),
    .store_type(store_type), .addr(addr), .wdata(wdata),
    .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  we;
    logic [31:0] d;
    bit          last;
  } beat_t;

  typedef struct {
    logic [1:0]  t;
    logic [31:0] a;
    logic [31:0] d;
    int          w0;
    int          w1;
    bit          gap;
    int          nb;
    logic [31:0] a0;
    logic [3:0]  we0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [3:0]  we1;
    logic [31:0] d1;
  } vec_t;

  beat_t sbq[$];
  vec_t  vt[11];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  // expected beats from per-lane byte selection
  task automatic push_model(input logic [1:0] t, input logic [31:0] a,
                            input logic [31:0] d);
    int sz, k;
    beat_t b0, b1;
    sz = (t == 2'd1) ? 1 : (t == 2'd2) ? 2 : 4;
    k  = int'(a[1:0]);
    b0.a = {a[31:2], 2'b00};
    b1.a = b0.a + 32'd4;
    b0.we = 4'd0; b1.we = 4'd0;
    b0.d = 32'd0; b1.d = 32'd0;
    for (int j = 0; j < 4; j++) begin
      if (j >= k) b0.d[8*j +: 8] = d[8*(j-k) +: 8];
      if (j < k)  b1.d[8*j +: 8] = d[8*(4-k+j) +: 8];
    end
    for (int i = 0; i < sz; i++) begin
      if (k + i < 4) b0.we[k+i] = 1'b1;
      else           b1.we[k+i-4] = 1'b1;
    end
    b0.last = (k + sz <= 4);
    b1.last = 1'b1;
    sbq.push_back(b0);
    if (!b0.last) sbq.push_back(b1);
  endtask

  task automatic push_vec(input vec_t v);
    beat_t b;
    b.a = v.a0; b.we = v.we0; b.d = v.d0; b.last = (v.nb == 1);
    sbq.push_back(b);
    if (v.nb == 2) begin
      b.a = v.a1; b.we = v.we1; b.d = v.d1; b.last = 1'b1;
      sbq.push_back(b);
    end
  endtask

  task automatic run_store(input logic [1:0] t, input logic [31:0] a,
                           input logic [31:0] d, input int w0,
                           input int w1, input bit gap, input bit drop);
    beat_t e;
    int bi, w;
    bit fin;
    @(posedge clk); #1;
    store_valid = 1'b1; store_type = t; addr = a; wdata = d;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("req_stall", {31'd0, stall}, 32'd1);
    chk("req_we", {28'd0, mem_we}, 32'd0);
    chk("req_done", {31'd0, done}, 32'd0);
    bi = 0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      w = (bi == 0) ? w0 : w1;
      for (int c = 0; c <= w; c++) begin
        @(posedge clk); #1;
        if (drop) store_valid = 1'b0;
        mem_ack = (c == w);
        fin = (c == w) && e.last;
        @(negedge clk);
        chk($sformatf("b%0d_addr", bi), mem_addr, e.a);
        chk($sformatf("b%0d_we", bi), {28'd0, mem_we}, {28'd0, e.we});
        chk($sformatf("b%0d_data", bi), mem_wdata, e.d);
        chk($sformatf("b%0d_done", bi), {31'd0, done}, {31'd0, fin});
        chk($sformatf("b%0d_stall", bi), {31'd0, stall}, {31'd0, !fin});
      end
      bi++;
    end
    if (gap) begin
      @(posedge clk); #1;
      store_valid = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
      chk("idle_we", {28'd0, mem_we}, 32'd0);
      chk("idle_addr", mem_addr, 32'd0);
      chk("idle_data", mem_wdata, 32'd0);
      chk("idle_stall", {31'd0, stall}, 32'd0);
    end
  endtask

  initial begin
    vt[0]  = '{2'd3, 32'h100, 32'hDEADBEEF, 0, 0, 1, 1,
               32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0};
    vt[1]  = '{2'd1, 32'h203, 32'h000000A5, 0, 0, 0, 1,
               32'h200, 4'h8, 32'hA5000000, 32'h0, 4'h0, 32'h0};
    vt[2]  = '{2'd2, 32'h307, 32'h00001234, 0, 0, 1, 2,
               32'h304, 4'h8, 32'h34000000, 32'h308, 4'h1, 32'h00000012};
    vt[3]  = '{2'd3, 32'h402, 32'h11223344, 3, 0, 1, 2,
               32'h400, 4'hC, 32'h33440000, 32'h404, 4'h3, 32'h00001122};
    vt[4]  = '{2'd3, 32'hFFFFFFFD, 32'hAABBCCDD, 0, 2, 1, 2,
               32'hFFFFFFFC, 4'hE, 32'hBBCCDD00, 32'h0, 4'h1, 32'h000000AA};
    vt[5]  = '{2'd2, 32'h502, 32'h9876BEEF, 0, 0, 0, 1,
               32'h500, 4'hC, 32'hBEEF0000, 32'h0, 4'h0, 32'h0};
    vt[6]  = '{2'd1, 32'h601, 32'hFFFFFF5A, 1, 0, 1, 1,
               32'h600, 4'h2, 32'hFFFF5A00, 32'h0, 4'h0, 32'h0};
    vt[7]  = '{2'd2, 32'h701, 32'h0000CAFE, 2, 0, 1, 1,
               32'h700, 4'h6, 32'h00CAFE00, 32'h0, 4'h0, 32'h0};
    vt[8]  = '{2'd3, 32'h803, 32'hA1B2C3D4, 1, 1, 0, 2,
               32'h800, 4'h8, 32'hD4000000, 32'h804, 4'h7, 32'h00A1B2C3};
    vt[9]  = '{2'd2, 32'h90B, 32'h5555ABCD, 0, 0, 0, 2,
               32'h908, 4'h8, 32'hCD000000, 32'h90C, 4'h1, 32'h005555AB};
    vt[10] = '{2'd1, 32'hA00, 32'h12345678, 0, 0, 1, 1,
               32'hA00, 4'h1, 32'h12345678, 32'h0, 4'h0, 32'h0};

    rst = 1'b1; store_valid = 1'b0; store_type = 2'd0;
    addr = 32'd0; wdata = 32'd0; mem_ack = 1'b0;
    #2;
    chk("rst_we", {28'd0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_data", mem_wdata, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      push_vec(vt[i]);
      run_store(vt[i].t, vt[i].a, vt[i].d, vt[i].w0, vt[i].w1,
                vt[i].gap, 1'b0);
    end

    // ignored type and ack while idle
    @(posedge clk); #1;
    store_valid = 1'b1; store_type = 2'd0; addr = 32'h123;
    wdata = 32'hFFFFFFFF; mem_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("none_stall", {31'd0, stall}, 32'd0);
      chk("none_we", {28'd0, mem_we}, 32'd0);
      chk("none_done", {31'd0, done}, 32'd0);
    end
    #1 store_valid = 1'b0; mem_ack = 1'b0;

    // illegal drop of store_valid must not abort the latched store
    push_model(2'd3, 32'hB01, 32'h0BADF00D);
    run_store(2'd3, 32'hB01, 32'h0BADF00D, 1, 1, 1'b1, 1'b1);

    for (int r = 0; r < 24; r++) begin
      logic [1:0]  t;
      logic [31:0] a, d;
      t = 2'($urandom_range(1, 3));
      a = $urandom; d = $urandom;
      push_model(t, a, d);
      run_store(t, a, d, $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), 1'b0);
    end

    // reset during beat0 of a split SW
    @(posedge clk); #1;
    store_valid = 1'b1; store_type = 2'd3; addr = 32'h1001;
    wdata = 32'hCAFEBABE; mem_ack = 1'b0;
    @(posedge clk); #1;
    store_valid = 1'b0;
    @(negedge clk);
    chk("rb_we", {28'd0, mem_we}, 32'hE);
    chk("rb_addr", mem_addr, 32'h1000);
    #1 rst = 1'b1; mem_ack = 1'b1;
    #1;
    chk("rb_rst_we", {28'd0, mem_we}, 32'd0);
    chk("rb_rst_addr", mem_addr, 32'd0);
    chk("rb_rst_data", mem_wdata, 32'd0);
    chk("rb_rst_stall", {31'd0, stall}, 32'd0);
    chk("rb_rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rb_post_we", {28'd0, mem_we}, 32'd0);
      chk("rb_post_addr", mem_addr, 32'd0);
      chk("rb_post_stall", {31'd0, stall}, 32'd0);
      chk("rb_post_done", {31'd0, done}, 32'd0);
    end
    mem_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
